// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: one-hot op encoding,
// FSM states and small op-decode helpers.
package ex_muldiv_pkg;

   localparam int MulDivOpCount = 8;

   localparam int MDOP_MUL_BIT    = 0;
   localparam int MDOP_MULH_BIT   = 1;
   localparam int MDOP_MULHSU_BIT = 2;
   localparam int MDOP_MULHU_BIT  = 3;
   localparam int MDOP_DIV_BIT    = 4;
   localparam int MDOP_DIVU_BIT   = 5;
   localparam int MDOP_REM_BIT    = 6;
   localparam int MDOP_REMU_BIT   = 7;

   typedef enum logic [MulDivOpCount-1:0] {
      MDOP_MUL    = 8'b0000_0001,
      MDOP_MULH   = 8'b0000_0010,
      MDOP_MULHSU = 8'b0000_0100,
      MDOP_MULHU  = 8'b0000_1000,
      MDOP_DIV    = 8'b0001_0000,
      MDOP_DIVU   = 8'b0010_0000,
      MDOP_REM    = 8'b0100_0000,
      MDOP_REMU   = 8'b1000_0000
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_DIV  = 2'd1,
      MD_DONE = 2'd2
   } muldiv_state_t;

   function automatic logic op_is_div(input muldiv_op_t op);
      return op[MDOP_DIV_BIT] | op[MDOP_DIVU_BIT] | op[MDOP_REM_BIT] | op[MDOP_REMU_BIT];
   endfunction

   function automatic logic op_is_mul(input muldiv_op_t op);
      return op[MDOP_MUL_BIT] | op[MDOP_MULH_BIT] | op[MDOP_MULHSU_BIT] | op[MDOP_MULHU_BIT];
   endfunction

   function automatic logic op_div_signed(input muldiv_op_t op);
      return op[MDOP_DIV_BIT] | op[MDOP_REM_BIT];
   endfunction

   function automatic logic op_is_rem(input muldiv_op_t op);
      return op[MDOP_REM_BIT] | op[MDOP_REMU_BIT];
   endfunction

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor when it fits. Requires rem_i < divisor_i.
module ex_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic            bit_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Trial subtraction; the top bit of diff is the borrow because |diff| < 2^XLEN.
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, divisor_i};
      q_o     = ~diff[XLEN];
      if (q_o) begin
         rem_o = diff[XLEN-1:0];
      end else begin
         rem_o = shifted[XLEN-1:0];
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M unit: single registered multiply, iterative
// restoring divider retiring DivBitsPerCycle quotient bits per clock.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter int DivBitsPerCycle = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  muldiv_op_t       op_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  rs2_i,
   input  logic             flush_i,
   output logic [XLEN-1:0]  result_o,
   output logic             done_o,
   output logic             busy_o,
   output logic             stallreq_o
);

   localparam int DivCycles = XLEN / DivBitsPerCycle;
   localparam int CntW      = $clog2(DivCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(DivCycles - 1);
   localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t   state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic            is_rem_q, is_rem_d, done_q, done_d;

   logic [2*XLEN-1:0] mul_a, mul_b, product;
   logic              div_signed, a_neg, b_neg;
   logic [XLEN-1:0]   rs1_mag, rs2_mag, quo_step, quo_fix, rem_fix;
   logic [XLEN-1:0]   step_rem [DivBitsPerCycle+1];
   logic [DivBitsPerCycle-1:0] step_q;

   assign mul_a   = {{XLEN{(op_i[MDOP_MULH_BIT] | op_i[MDOP_MULHSU_BIT]) & rs1_i[XLEN-1]}}, rs1_i};
   assign mul_b   = {{XLEN{op_i[MDOP_MULH_BIT] & rs2_i[XLEN-1]}}, rs2_i};
   assign product = mul_a * mul_b;

   assign div_signed = op_div_signed(op_i);
   assign a_neg      = div_signed & rs1_i[XLEN-1];
   assign b_neg      = div_signed & rs2_i[XLEN-1];
   assign rs1_mag    = a_neg ? -rs1_i : rs1_i;
   assign rs2_mag    = b_neg ? -rs2_i : rs2_i;

   // Step chain consumes dividend bits MSB-first out of the quotient register.
   assign step_rem[0] = rem_q;
   for (genvar j = 0; j < DivBitsPerCycle; j++) begin : g_step
      ex_div_step #(.XLEN(XLEN)) u_step (
         .rem_i     (step_rem[j]),
         .bit_i     (quo_q[XLEN-1-j]),
         .divisor_i (dvs_q),
         .rem_o     (step_rem[j+1]),
         .q_o       (step_q[DivBitsPerCycle-1-j])
      );
   end

   assign quo_step = (quo_q << DivBitsPerCycle) | XLEN'(step_q);
   assign quo_fix  = neg_quo_q ? -quo_step : quo_step;
   assign rem_fix  = neg_rem_q ? -step_rem[DivBitsPerCycle] : step_rem[DivBitsPerCycle];

   // Next-state and datapath update; flush overrides everything and leaves result alone.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      result_d  = result_q;
      done_d    = 1'b0;
      if (flush_i) begin
         state_d = MD_IDLE;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (!start_i) begin
                  state_d = MD_IDLE;
               end else if (op_is_mul(op_i) || !op_is_div(op_i)) begin
                  result_d = op_i[MDOP_MUL_BIT] ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                  done_d   = 1'b1;
                  state_d  = MD_DONE;
               end else if (rs2_i == '0) begin
                  result_d = op_is_rem(op_i) ? rs1_i : '1;
                  done_d   = 1'b1;
                  state_d  = MD_DONE;
               end else if (div_signed && (rs1_i == MostNeg) && (rs2_i == '1)) begin
                  result_d = op_is_rem(op_i) ? '0 : rs1_i;
                  done_d   = 1'b1;
                  state_d  = MD_DONE;
               end else begin
                  cnt_d     = '0;
                  rem_d     = '0;
                  quo_d     = rs1_mag;
                  dvs_d     = rs2_mag;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  is_rem_d  = op_is_rem(op_i);
                  state_d   = MD_DIV;
               end
            end
            MD_DIV: begin
               rem_d = step_rem[DivBitsPerCycle];
               quo_d = quo_step;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  result_d = is_rem_q ? rem_fix : quo_fix;
                  done_d   = 1'b1;
                  state_d  = MD_DONE;
               end else begin
                  state_d = MD_DIV;
               end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
         result_q  <= result_d;
         done_q    <= done_d;
      end
   end

   assign result_o   = result_q;
   assign done_o     = done_q;
   assign busy_o     = (state_q != MD_IDLE);
   assign stallreq_o = start_i & ~done_q & ~flush_i;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table run on a radix-2 and a
// 4-bits-per-cycle instance, plus flush and async-reset sequences.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0, start4 = 1'b0, flush = 1'b0;
   muldiv_op_t  op = MDOP_MUL;
   logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
   logic [31:0] res1, res4;
   logic        done1, busy1, stall1, done4, busy4, stall4;

   int tests = 0;
   int fails = 0;

   typedef struct {
      muldiv_op_t  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat1;
      int          lat4;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   ex_muldiv #(.XLEN(32), .DivBitsPerCycle(1)) dut (
      .clk(clk), .rst(rst), .start_i(start1), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
      .flush_i(flush), .result_o(res1), .done_o(done1), .busy_o(busy1), .stallreq_o(stall1)
   );

   ex_muldiv #(.XLEN(32), .DivBitsPerCycle(4)) dut4 (
      .clk(clk), .rst(rst), .start_i(start4), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
      .flush_i(flush), .result_o(res4), .done_o(done4), .busy_o(busy4), .stallreq_o(stall4)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat1 = 0, lat4 = 0;
      logic [31:0] r1 = 32'd0, r4 = 32'd0;
      bit seen1 = 0, seen4 = 0, drop1 = 0, drop4 = 0;
      @(negedge clk);
      op = v.op; rs1 = v.a; rs2 = v.b; start1 = 1'b1; start4 = 1'b1;
      #1;
      chk($sformatf("v%0d_stall_k", idx), {62'd0, stall1, stall4}, 64'd3);
      for (int c = 1; c <= 60 && !(drop1 && drop4); c++) begin
         @(posedge clk); #1;
         if (!seen1 && done1) begin
            seen1 = 1; lat1 = c; r1 = res1;
            chk($sformatf("v%0d_stall_done1", idx), {63'd0, stall1}, 64'd0);
         end else if (seen1 && !drop1) begin
            chk($sformatf("v%0d_done1_width", idx), {63'd0, done1}, 64'd0);
            start1 = 1'b0; drop1 = 1;
         end
         if (!seen4 && done4) begin
            seen4 = 1; lat4 = c; r4 = res4;
         end else if (seen4 && !drop4) begin
            chk($sformatf("v%0d_done4_width", idx), {63'd0, done4}, 64'd0);
            start4 = 1'b0; drop4 = 1;
         end
      end
      start1 = 1'b0; start4 = 1'b0;
      chk($sformatf("v%0d_completed", idx), {62'd0, drop1, drop4}, 64'd3);
      chk($sformatf("v%0d_lat1", idx), 64'(lat1), 64'(v.lat1));
      chk($sformatf("v%0d_res1", idx), {32'd0, r1}, {32'd0, v.exp});
      chk($sformatf("v%0d_lat4", idx), 64'(lat4), 64'(v.lat4));
      chk($sformatf("v%0d_res4", idx), {32'd0, r4}, {32'd0, v.exp});
   endtask

   initial begin
      bit saw_done;
      vec_t v;

      vecs[0]  = '{MDOP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 1};
      vecs[1]  = '{MDOP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1};
      vecs[2]  = '{MDOP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1, 1};
      vecs[3]  = '{MDOP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1, 1};
      vecs[4]  = '{MDOP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1};
      vecs[5]  = '{MDOP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1};
      vecs[6]  = '{MDOP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 9};
      vecs[7]  = '{MDOP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 9};
      vecs[8]  = '{MDOP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1};
      vecs[9]  = '{MDOP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, 1};
      vecs[10] = '{MDOP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1};
      vecs[11] = '{MDOP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1};
      vecs[12] = '{MDOP_DIVU,   32'd100,       32'd7,         32'd14,        33, 9};
      vecs[13] = '{MDOP_REMU,   32'd100,       32'd7,         32'd2,         33, 9};
      vecs[14] = '{MDOP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 9};
      vecs[15] = '{MDOP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33, 9};
      vecs[16] = '{MDOP_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, 9};
      vecs[17] = '{MDOP_MUL,    32'd3,         32'd4,         32'd12,        1, 1};
      vecs[18] = '{MDOP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 9};

      // Reset state
      #3;
      chk("rst_result", {32'd0, res1}, 64'd0);
      chk("rst_flags", {60'd0, done1, busy1, stall1, done4}, 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i], i);
      end

      // flush while idle blocks acceptance
      @(negedge clk);
      op = MDOP_MUL; rs1 = 32'd5; rs2 = 32'd6; start1 = 1'b1; flush = 1'b1;
      #1;
      chk("idle_flush_stall", {63'd0, stall1}, 64'd0);
      @(posedge clk); #1;
      chk("idle_flush_busy", {62'd0, busy1, done1}, 64'd0);
      start1 = 1'b0; flush = 1'b0;

      // flush mid-divide, then a multiply accepted right after
      @(negedge clk);
      op = MDOP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start1 = 1'b1;
      @(posedge clk);
      saw_done = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         #1;
         if (done1) saw_done = 1'b1;
         @(posedge clk);
      end
      #1;
      flush = 1'b1;
      #1;
      chk("flush_stall", {63'd0, stall1}, 64'd0);
      chk("flush_busy_before", {63'd0, busy1}, 64'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy_after", {63'd0, busy1}, 64'd0);
      chk("flush_no_done", {62'd0, done1, saw_done}, 64'd0);
      chk("flush_result_kept", {32'd0, res1}, {32'd0, vecs[NV-1].exp});
      op = MDOP_MUL; rs1 = 32'd3; rs2 = 32'd4; start1 = 1'b1;
      @(posedge clk); #1;
      chk("post_flush_done", {63'd0, done1}, 64'd1);
      chk("post_flush_res", {32'd0, res1}, 64'd12);
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("post_flush_done_width", {63'd0, done1}, 64'd0);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      op = MDOP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start1 = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #3;
      chk("pre_rst_busy", {63'd0, busy1}, 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_flags", {62'd0, busy1, done1}, 64'd0);
      chk("async_rst_result", {32'd0, res1}, 64'd0);
      start1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      v = '{MDOP_DIVU, 32'd9, 32'd3, 32'd3, 33, 9};
      run_vec(v, 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
